spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 144 ++++++++++++++
 tb/tb_spi_peripheral.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only peripheral: five 8-bit configuration registers loaded from
// 16-bit frames {R/W, addr[6:0], data[7:0]} clocked in on sclk while ncs is low.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int unsigned NUM_REGS = 5;
  localparam logic [4:0]  CNT_FULL = 5'd16;
  localparam logic [4:0]  CNT_SAT  = 5'd17;

  // Synchronizer chains, one extra delay flop each for edge detection.
  logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, copi_sync_q;
  logic                   ncs_dly_q, sclk_dly_q, copi_dly_q;
  // Fills with ones after reset; until full, ncs_dly_q still holds its reset
  // value, so an ncs held low through reset must not look like a fresh fall.
  logic [SYNC_STAGES:0]   prime_q;

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];

  logic ncs_s, sclk_s, primed;
  logic ncs_fall, ncs_rise, sclk_rise;
  logic commit;

  // NOTE: every clocked element below uses non-blocking assignments so all flops
  // update together from the values they held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_sync_q  <= '1;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_dly_q   <= 1'b1;
      sclk_dly_q  <= 1'b0;
      copi_dly_q  <= 1'b0;
      prime_q     <= '0;
    end else begin
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      copi_dly_q  <= copi_sync_q[SYNC_STAGES-1];
      prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign primed    = prime_q[SYNC_STAGES];
  assign ncs_fall  = primed & ~ncs_s & ncs_dly_q;
  assign ncs_rise  = primed & ncs_s & ~ncs_dly_q;
  assign sclk_rise = sclk_s & ~sclk_dly_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = RECV;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      RECV: begin
        // ncs rise wins over a coincident sclk rise; decision uses pre-edge count.
        if (ncs_rise) begin
          state_d = IDLE;
          commit  = (cnt_q == CNT_FULL) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);
        end else if (ncs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
        end else if (sclk_rise) begin
          // copi is stable across the whole low phase, so its delayed copy is valid here.
          shift_d = {shift_q[14:0], copi_dly_q};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (shift_q[14:8] == 7'(i))) begin
        regs_d[i] = shift_q[7:0];
      end
    end
  end

  // NOTE: the register file is only five bytes and its outputs must read 0 after
  // reset, so it is reset explicitly rather than left as an unreset memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a table of frames with expected register
// contents, plus hand-written sequences for latency, reset, glitch and edge races.
module tb_spi_peripheral;

  localparam int HALF = 4;   // sclk phase and minimum ncs gap, in clk periods

  logic       clk = 1'b0;
  logic       rst, ncs, sclk, copi;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int n_checks = 0;
  int n_errors = 0;

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk             (clk),
    .rst             (rst),
    .ncs             (ncs),
    .sclk            (sclk),
    .copi            (copi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] frame;
    int          nbits;
    logic [7:0]  e_out0, e_out1, e_pwm0, e_pwm1, e_duty;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] d);
    check({tag, ".out_7_0"},  en_reg_out_7_0,  e0);
    check({tag, ".out_15_8"}, en_reg_out_15_8, e1);
    check({tag, ".pwm_7_0"},  en_reg_pwm_7_0,  p0);
    check({tag, ".pwm_15_8"}, en_reg_pwm_15_8, p1);
    check({tag, ".duty"},     pwm_duty_cycle,  d);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    ncs = 1'b0;
    wait_clks(HALF);
  endtask

  // Bits beyond the 16th are sent as 0.
  task automatic shift_bits(input logic [15:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? frame[15-i] : 1'b0;
      wait_clks(HALF);
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
  endtask

  // Raise ncs and return just after the 3rd rising edge, when a commit is visible.
  task automatic end_frame();
    wait_clks(HALF);
    ncs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Completes the minimum ncs-high gap after end_frame's check point.
  task automatic finish_gap();
    repeat (HALF - 2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"wr_duty",    16'h8480, 16, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80};
    vecs[1] = '{"wr_pwm0",    16'h8201, 16, 8'hF0, 8'h00, 8'h01, 8'h00, 8'h80};
    vecs[2] = '{"wr_out0_ff", 16'h80FF, 16, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80};
    vecs[3] = '{"rd_frame",   16'h00AA, 16, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80};
    vecs[4] = '{"out_range",  16'h85AA, 16, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80};
    vecs[5] = '{"short15",    16'h80AA, 15, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80};
    vecs[6] = '{"long17",     16'h80AA, 17, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h80};
    vecs[7] = '{"b2b_first",  16'h8011, 16, 8'h11, 8'h00, 8'h01, 8'h00, 8'h80};
    vecs[8] = '{"b2b_second", 16'h8122, 16, 8'h11, 8'h22, 8'h01, 8'h00, 8'h80};

    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(HALF);
    check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // First write: output must change exactly on the 3rd edge after ncs rises.
    start_frame();
    shift_bits(16'h80F0, 16);
    wait_clks(HALF);
    ncs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("latency.edge2", en_reg_out_7_0, 8'h00);
    @(posedge clk);
    #1;
    check_all("latency.edge3", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
    finish_gap();

    for (int v = 0; v < 9; v++) begin
      start_frame();
      shift_bits(vecs[v].frame, vecs[v].nbits);
      end_frame();
      check_all(vecs[v].name, vecs[v].e_out0, vecs[v].e_out1, vecs[v].e_pwm0,
                vecs[v].e_pwm1, vecs[v].e_duty);
      finish_gap();
    end

    // Reset mid-frame with ncs held low: rest of that frame must be ignored.
    start_frame();
    shift_bits(16'h8155, 8);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    wait_clks(1);
    check_all("midrst.cleared", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    shift_bits(16'h5500, 8);
    end_frame();
    check_all("midrst.discard", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    finish_gap();
    start_frame();
    shift_bits(16'h8155, 16);
    end_frame();
    check_all("midrst.fresh", 8'h00, 8'h55, 8'h00, 8'h00, 8'h00);
    finish_gap();

    // One-clk ncs glitch after a partial byte, then a full frame.
    start_frame();
    shift_bits(16'h80FF, 8);
    wait_clks(HALF);
    ncs = 1'b1;
    wait_clks(1);
    ncs = 1'b0;
    wait_clks(HALF);
    check_all("glitch.partial", 8'h00, 8'h55, 8'h00, 8'h00, 8'h00);
    shift_bits(16'h83C3, 16);
    end_frame();
    check_all("glitch.full", 8'h00, 8'h55, 8'h00, 8'hC3, 8'h00);
    finish_gap();

    // 17th sclk rise coincides with ncs rise: frame still counts as 16 bits.
    start_frame();
    shift_bits(16'h80AB, 16);
    wait_clks(HALF);
    sclk = 1'b1;
    ncs  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("race", 8'hAB, 8'h55, 8'h00, 8'hC3, 8'h00);
    @(negedge clk);
    sclk = 1'b0;
    wait_clks(HALF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
